// File: rtl/multiword_adder.sv
// Streaming multi-beat adder/subtractor: one WIDTH-bit slice per beat, least-significant
// word first, carry/borrow held between beats, single registered output stage.
module multiword_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_first,
  input  logic             in_last,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             out_last,
  output logic             cout,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             carry_q, carry_d;
  logic             mode_q, mode_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             last_q, last_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;

  logic             accept_s, start_s, cont_s;
  logic             mode_eff_s, cin_s;
  logic [WIDTH-1:0] b_eff_s;
  logic [WIDTH:0]   full_s;
  logic [WIDTH-1:0] low_s;
  logic             ovf_s;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign sum       = sum_q;
  assign out_last  = last_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign err       = err_q;

  // Beat arithmetic: a first beat (also when it aborts a running operand) seeds carry with sub.
  always_comb begin
    accept_s   = in_valid && in_ready;
    start_s    = accept_s && in_first;
    cont_s     = accept_s && !in_first && (state_q == BUSY);
    mode_eff_s = start_s ? sub : mode_q;
    cin_s      = start_s ? sub : carry_q;
    b_eff_s    = mode_eff_s ? ~b : b;
    full_s     = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, cin_s};
    // low_s[WIDTH-1] is the carry into the MSB position
    low_s      = {1'b0, a[WIDTH-2:0]} + {1'b0, b_eff_s[WIDTH-2:0]} + {{(WIDTH-1){1'b0}}, cin_s};
    ovf_s      = low_s[WIDTH-1] ^ full_s[WIDTH];
  end

  // Next-state, carry/mode and output-register update.
  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    mode_d  = mode_q;
    valid_d = valid_q;
    sum_d   = sum_q;
    last_d  = last_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    err_d   = accept_s && (((state_q == IDLE) && !in_first) || ((state_q == BUSY) && in_first));

    if (start_s || cont_s) begin
      state_d = in_last ? IDLE : BUSY;
      carry_d = full_s[WIDTH];
      mode_d  = mode_eff_s;
      valid_d = 1'b1;
      sum_d   = full_s[WIDTH-1:0];
      last_d  = in_last;
      cout_d  = in_last ? full_s[WIDTH] : 1'b0;
      ovf_d   = in_last ? ovf_s : 1'b0;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      carry_q <= 1'b0;
      mode_q  <= 1'b0;
      valid_q <= 1'b0;
      sum_q   <= {WIDTH{1'b0}};
      last_q  <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      carry_q <= carry_d;
      mode_q  <= mode_d;
      valid_q <= valid_d;
      sum_q   <= sum_d;
      last_q  <= last_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_multiword_adder.sv
// Directed bench for multiword_adder (WIDTH=8); inputs change and outputs are sampled on negedge.
module tb_multiword_adder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       in_first;
  logic       in_last;
  logic       sub;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       out_last;
  logic       cout;
  logic       ovf;
  logic       err;

  int n_cmp;
  int n_bad;

  multiword_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first), .in_last(in_last),
    .sub(sub), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .out_last(out_last),
    .cout(cout), .ovf(ovf), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Packed view {out_valid, out_last, cout, ovf, err, sum}
  function automatic logic [12:0] obs();
    return {out_valid, out_last, cout, ovf, err, sum};
  endfunction

  // Present one beat at the current negedge, let it transfer, return at the next negedge.
  task automatic send(input logic f, input logic l, input logic s,
                      input logic [7:0] av, input logic [7:0] bv);
    in_valid = 1'b1; in_first = f; in_last = l; sub = s; a = av; b = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sub = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++;
    if (obs() !== 13'h0000) begin
      n_bad++; $display("FAIL reset_outputs: got %h expected %h", obs(), 13'h0000);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_single_add();
    send(1'b1, 1'b1, 1'b0, 8'hFF, 8'h01);
    n_cmp++;
    if (obs() !== {5'b11100, 8'h00}) begin
      n_bad++; $display("FAIL single_add: got %h expected %h", obs(), {5'b11100, 8'h00});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL single_add_drain: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_two_beat_add();
    send(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01);
    n_cmp++;
    if (obs() !== {5'b10000, 8'h00}) begin
      n_bad++; $display("FAIL two_add_b0: got %h expected %h", obs(), {5'b10000, 8'h00});
    end
    send(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    n_cmp++;
    if (obs() !== {5'b11000, 8'h02}) begin
      n_bad++; $display("FAIL two_add_b1: got %h expected %h", obs(), {5'b11000, 8'h02});
    end
  endtask

  task automatic test_sub();
    send(1'b1, 1'b1, 1'b1, 8'h80, 8'h01);
    n_cmp++;
    if (obs() !== {5'b11110, 8'h7F}) begin
      n_bad++; $display("FAIL sub_ovf: got %h expected %h", obs(), {5'b11110, 8'h7F});
    end
    send(1'b1, 1'b0, 1'b1, 8'h00, 8'h01);
    n_cmp++;
    if (obs() !== {5'b10000, 8'hFF}) begin
      n_bad++; $display("FAIL sub2_b0: got %h expected %h", obs(), {5'b10000, 8'hFF});
    end
    // sub is ignored on non-first beats; the latched mode must stay subtract
    send(1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    n_cmp++;
    if (obs() !== {5'b11000, 8'hFF}) begin
      n_bad++; $display("FAIL sub2_b1: got %h expected %h", obs(), {5'b11000, 8'hFF});
    end
  endtask

  // 0x01FFFF + 0x000001 with a 3-cycle stall after the first result.
  task automatic test_backpressure();
    send(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01);
    out_ready = 1'b0;
    in_valid = 1'b1; in_first = 1'b0; in_last = 1'b0; a = 8'hFF; b = 8'h00;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      n_cmp++;
      if ({in_ready, obs()} !== {1'b0, 5'b10000, 8'h00}) begin
        n_bad++; $display("FAIL bp_hold%0d: got %h expected %h", i, {in_ready, obs()},
                          {1'b0, 5'b10000, 8'h00});
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (obs() !== {5'b10000, 8'h00}) begin
      n_bad++; $display("FAIL bp_b1: got %h expected %h", obs(), {5'b10000, 8'h00});
    end
    send(1'b0, 1'b1, 1'b0, 8'h01, 8'h00);
    n_cmp++;
    if (obs() !== {5'b11000, 8'h02}) begin
      n_bad++; $display("FAIL bp_b2: got %h expected %h", obs(), {5'b11000, 8'h02});
    end
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++; $display("FAIL bp_no_dup: out_valid got %b expected 0", out_valid);
    end
  endtask

  task automatic test_protocol_err();
    send(1'b0, 1'b1, 1'b0, 8'h11, 8'h22);
    n_cmp++;
    if ({out_valid, err} !== 2'b01) begin
      n_bad++; $display("FAIL err_idle: valid/err got %b expected 01", {out_valid, err});
    end
    @(negedge clk);
    n_cmp++;
    if ({out_valid, err} !== 2'b00) begin
      n_bad++; $display("FAIL err_pulse_end: valid/err got %b expected 00", {out_valid, err});
    end
    send(1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF);
    n_cmp++;
    if (obs() !== {5'b10000, 8'hFE}) begin
      n_bad++; $display("FAIL abort_b0: got %h expected %h", obs(), {5'b10000, 8'hFE});
    end
    // stored carry is 1; the restarted operand must use carry_in = sub = 0
    send(1'b1, 1'b1, 1'b0, 8'h01, 8'h01);
    n_cmp++;
    if (obs() !== {5'b11001, 8'h02}) begin
      n_bad++; $display("FAIL abort_restart: got %h expected %h", obs(), {5'b11001, 8'h02});
    end
  endtask

  task automatic test_reset_mid();
    send(1'b1, 1'b0, 1'b0, 8'hFF, 8'h01);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({in_ready, obs()} !== {1'b1, 13'h0000}) begin
      n_bad++; $display("FAIL async_reset: got %h expected %h", {in_ready, obs()}, {1'b1, 13'h0000});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
    n_cmp++;
    if ({out_valid, err} !== 2'b01) begin
      n_bad++; $display("FAIL post_reset_err: valid/err got %b expected 01", {out_valid, err});
    end
    send(1'b1, 1'b1, 1'b1, 8'h03, 8'h01);
    n_cmp++;
    if (obs() !== {5'b11100, 8'h02}) begin
      n_bad++; $display("FAIL post_reset_sub: got %h expected %h", obs(), {5'b11100, 8'h02});
    end
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; sub = 1'b0;
    a = 8'h00; b = 8'h00; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    test_reset();
    test_single_add();
    test_two_beat_add();
    test_sub();
    test_backpressure();
    test_protocol_err();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
